// File: rtl/rom_seq_ctrl.sv
// Playback controller for the LED pattern ROM: steps a windowed address range
// at a programmable rate, single-shot or looping, with start/stop/pause control.
module rom_seq_ctrl #(
    parameter int AW         = 5,
    parameter int PW         = 24,
    parameter int PERIOD_MIN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          loop,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    input  logic [PW-1:0] period,
    output logic [AW-1:0] address,
    output logic          busy,
    output logic          step,
    output logic          wrap,
    output logic          done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_r;
    logic [PW-1:0] cnt_r;
    logic [PW-1:0] plast_r;
    logic [AW-1:0] first_r;
    logic [AW-1:0] last_r;
    logic          loop_r;

    // Terminal count (P-1) for the effective period P = max(period, PERIOD_MIN).
    function automatic logic [PW-1:0] period_last(input logic [PW-1:0] p);
        if (p < PW'(PERIOD_MIN)) begin
            return PW'(PERIOD_MIN) - PW'(1);
        end else begin
            return p - PW'(1);
        end
    endfunction

    // Playback state machine; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            address <= {AW{1'b0}};
            busy    <= 1'b0;
            step    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            cnt_r   <= {PW{1'b0}};
            plast_r <= {PW{1'b0}};
            first_r <= {AW{1'b0}};
            last_r  <= {AW{1'b0}};
            loop_r  <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            done <= 1'b0;
            if (stop) begin
                state_r <= IDLE;
                busy    <= 1'b0;
            end else if (start) begin
                // Start from IDLE and restart in RUN share the same load.
                state_r <= RUN;
                busy    <= 1'b1;
                step    <= 1'b1;
                address <= first_addr;
                cnt_r   <= {PW{1'b0}};
                plast_r <= period_last(period);
                first_r <= first_addr;
                last_r  <= last_addr;
                loop_r  <= loop;
            end else begin
                case (state_r)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN: begin
                        if (pause) begin
                            cnt_r <= cnt_r;
                        end else if (cnt_r != plast_r) begin
                            cnt_r <= cnt_r + PW'(1);
                        end else begin
                            cnt_r <= {PW{1'b0}};
                            if (address != last_r) begin
                                address <= address + AW'(1);
                                step    <= 1'b1;
                            end else if (loop_r) begin
                                address <= first_r;
                                step    <= 1'b1;
                                wrap    <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Scoreboard bench for rom_seq_ctrl: expected outputs are derived from the
// run configuration and cycle index, queued as stimulus is driven.
module tb_rom_seq_ctrl;
    localparam int AW = 5;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst, start, stop, pause, loop;
    logic [AW-1:0] first_addr, last_addr;
    logic [PW-1:0] period;
    logic [AW-1:0] address;
    logic          busy, step, wrap, done;

    int            errors = 0;
    int            checks = 0;
    logic [8:0]    exp_q[$];
    logic [8:0]    last_exp;
    string         tag;

    // Run configuration used by the expectation model.
    int cf, cl, cp, clp;

    rom_seq_ctrl #(.AW(AW), .PW(PW), .PERIOD_MIN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop(loop), .first_addr(first_addr), .last_addr(last_addr),
        .period(period), .address(address), .busy(busy), .step(step),
        .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (addr,busy,step,wrap,done)", t, got, exp);
        end
    endtask

    // Expected {address, busy, step, wrap, done} k cycles after the start step.
    function automatic logic [8:0] exp_at(input int k);
        int n, p, i;
        logic [4:0] a;
        logic b, s, w, d;
        n = ((cl - cf) & 31) + 1;
        p = (cp == 0) ? 1 : cp;
        i = k / p;
        d = 1'b0;
        w = 1'b0;
        if (clp != 0) begin
            a = 5'(cf + (i % n));
            s = (k % p) == 0;
            w = s && (i > 0) && ((i % n) == 0);
            b = 1'b1;
        end else if (k < n * p) begin
            a = 5'(cf + i);
            s = (k % p) == 0;
            b = 1'b1;
        end else begin
            a = 5'(cl);
            s = 1'b0;
            b = 1'b0;
            d = (k == n * p);
        end
        return {a, b, s, w, d};
    endfunction

    task automatic cyc();
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, {23'd0, address, busy, step, wrap, done}, {23'd0, e});
        end else begin
            check({tag, "_underflow"}, 32'd0, 32'd1);
        end
    endtask

    task automatic push(input logic [8:0] e);
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic launch(input int f, input int l, input int p, input int lp);
        first_addr = 5'(f);
        last_addr  = 5'(l);
        period     = 24'(p);
        loop       = lp[0];
        start      = 1'b1;
        cf = f; cl = l; cp = p; clp = lp;
        push(exp_at(0));
        cyc();
        start      = 1'b0;
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);
        period     = 24'($urandom_range(0, 7));
        loop       = 1'($urandom);
    endtask

    task automatic run_to(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            push(exp_at(k));
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        first_addr = 5'd0; last_addr = 5'd0; period = 24'd0;
        tag = "reset";
        push(9'd0); cyc();
        push(9'd0); cyc();
        rst = 1'b0;
        push(9'd0); cyc();

        tag = "single";
        launch(0, 3, 4, 0);
        run_to(1, 19);

        tag = "loop";
        launch(12, 15, 2, 1);
        run_to(1, 20);
        tag = "loop_stop";
        stop = 1'b1;
        push({last_exp[8:4], 4'b0000}); cyc();
        stop = 1'b0;
        push({last_exp[8:4], 4'b0000}); cyc();

        tag = "modulo";
        launch(30, 1, 1, 0);
        run_to(1, 6);

        tag = "period0";
        launch(3, 6, 0, 0);
        run_to(1, 6);

        tag = "pause";
        launch(4, 8, 3, 0);
        run_to(1, 4);
        pause = 1'b1;
        for (int j = 0; j < 5; j++) begin
            push(exp_at(4));
            cyc();
        end
        pause = 1'b0;
        run_to(5, 17);

        tag = "reset_mid";
        launch(10, 20, 1, 0);
        run_to(1, 3);
        rst = 1'b1;
        push(9'd0); cyc();
        push(9'd0); cyc();
        rst = 1'b0;
        push(9'd0); cyc();

        tag = "restart";
        launch(2, 20, 2, 0);
        run_to(1, 10);
        launch(9, 12, 2, 0);
        run_to(1, 10);

        tag = "start_stop";
        launch(1, 2, 5, 0);
        run_to(1, 2);
        start = 1'b1;
        stop  = 1'b1;
        push({5'd1, 4'b0000}); cyc();
        start = 1'b0;
        stop  = 1'b0;
        push({5'd1, 4'b0000}); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_seq_ctrl.md
Name: rom_seq_ctrl

Overview:
Playback controller for the 32-entry LED pattern ROM. It steps the ROM address through a programmable window [first_addr..last_addr] at a programmable rate, in single-shot or looping mode. It provides start, stop and pause control plus status pulses for the surrounding top level. The ROM samples the address on the falling clock edge, so the leds value for a new address is valid half a cycle after this block updates it.

Parameters:
AW, 5, address width (ROM depth 2^AW = 32)
PW, 24, width of step-period counter
PERIOD_MIN, 1, effective period used when period input is 0

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  level sampled each cycle; begins or restarts playback
stop  input  1  aborts playback; has priority over start
pause  input  1  while high in RUN, freezes period counter and address
loop  input  1  sampled at start: 1 = wrap to first_addr after last_addr, 0 = single shot
first_addr  input  AW  window start, latched at start
last_addr  input  AW  window end, latched at start
period  input  PW  clk cycles per ROM step, latched at start; 0 treated as PERIOD_MIN
address  output  AW  ROM address
busy  output  1  high in RUN
step  output  1  one-cycle pulse whenever address is loaded or advances
wrap  output  1  one-cycle pulse when a looping run returns to first_addr
done  output  1  one-cycle pulse when a single-shot run completes

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, address=0, busy=0, step=0, wrap=0, done=0, period counter=0, latched config=0. Reset mid-run aborts at once with no done pulse.
- States: IDLE, RUN. step, wrap and done are registered and default to 0 every cycle.
- IDLE, start=1, stop=0 -> next cycle: RUN, address=first_addr, busy=1, step=1. first/last/period/loop are latched and counter=0. Later input changes are ignored until the next start.
- RUN, stop=1 -> next cycle: IDLE, busy=0, address holds its current value, no done pulse.
- RUN, start=1, stop=0 -> restart: re-latch config, address=first_addr, counter=0, step=1, no done or wrap pulse.
- RUN, pause=1, no start/stop -> counter and address hold; no pulses.
- RUN, otherwise -> counter increments while counter < P-1, where P = max(period, PERIOD_MIN). When counter == P-1:
  - counter=0.
  - If address != last: address = address+1 modulo 2^AW; step=1.
  - If address == last and loop=1: address=first; step=1; wrap=1.
  - If address == last and loop=0: state=IDLE; busy=0; done=1; address holds last; no step.
- Dwell: each address is held for exactly P cycles. A single-shot window of N addresses keeps busy high for N*P cycles from the first step.
- Wrap-around: if first > last, the address increments through 2^AW-1 to 0 and on to last. If first == last, the window has one entry.
- Priority per cycle: rst > stop > start > pause > count.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN -> address=0, busy=0, no done; the ROM then shows leds=4'h1.
- Single shot: first=0, last=3, period=4, loop=0, pulse start -> address 0,1,2,3, each held 4 cycles; step pulses 4 times; done pulses once 16 cycles after the first step; busy falls with done; address stays 3.
- Loop with wrap: first=12, last=15, period=2, loop=1 -> addresses 12,13,14,15,12,...; wrap pulses every 8 cycles; leds sequence C,3,C,3; done never pulses.
- Modulo window: first=30, last=1, period=1, loop=0 -> address 30,31,0,1; done one cycle after address 1.
- Period 0 and pause: period=0 -> address advances every cycle. In another run with period=3, holding pause 5 cycles at address 5 keeps address=5 with no step pulse; counting resumes from the frozen counter value.
- Stop/start collisions: start and stop high together in RUN -> IDLE, no done. Start in RUN at address 7 with first=9 -> address=9 next cycle, step=1, counter=0.
